// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger
//   Controller for an HC-SR04-style ultrasonic range sensor. It issues a
//   trigger pulse once per measurement period, times the width of the echo
//   pulse that comes back, and holds the range in whole centimetres.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   echo      in   sensor echo (asynchronous pad input)
//   trigger   out  sensor trigger pulse, registered
//   distance  out  14-bit last measured range in cm, registered
//                  (14'h3FFF means no target within the timeout)
//
// Build option
//   ULTRASONIC_ECHO_SYNC_EN : when defined, echo passes through a 2-flop
//   synchroniser ahead of the edge-detect flop (3-cycle edge latency).
//   When undefined, echo feeds the edge-detect flop directly (1-cycle
//   latency) and must already be synchronous to clk. Both echo edges see
//   the same delay, so the measured distance is identical either way.

module ultrasonic_ranger #(
  parameter int unsigned TICKS_PER_US = 100,
  parameter int unsigned TRIG_US      = 10,
  parameter int unsigned US_PER_CM    = 58,
  parameter int unsigned TIMEOUT_US   = 30000,
  parameter int unsigned CYCLE_US     = 60000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        echo,
  output logic        trigger,
  output logic [13:0] distance
);

  // Timeout and period are counted in raw clocks rather than microseconds:
  // the echo edges that end WAIT_ECHO and MEASURE are not aligned to the
  // microsecond prescaler, so counting ticks across states would drift.
  localparam int unsigned TO_CYC  = TIMEOUT_US * TICKS_PER_US;
  localparam int unsigned CYC_CYC = CYCLE_US * TICKS_PER_US;

  localparam int unsigned PRESC_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int unsigned TRIG_W  = (TRIG_US > 1)      ? $clog2(TRIG_US)      : 1;
  localparam int unsigned SUB_W   = (US_PER_CM > 1)    ? $clog2(US_PER_CM)    : 1;
  localparam int unsigned TO_W    = (TO_CYC > 1)       ? $clog2(TO_CYC)       : 1;
  localparam int unsigned CYC_W   = (CYC_CYC > 1)      ? $clog2(CYC_CYC)      : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_US - 1);
  localparam logic [TRIG_W-1:0]  TRIG_LAST  = TRIG_W'(TRIG_US - 1);
  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(US_PER_CM - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TO_CYC - 1);
  localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(CYC_CYC - 1);

  localparam logic [13:0] NO_TARGET = 14'h3FFF;

  typedef enum logic [1:0] {
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_HOLD
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic [TRIG_W-1:0]  trig_cnt;
  logic [SUB_W-1:0]   sub_cnt;
  logic [13:0]        cm_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [CYC_W-1:0]   cyc_cnt;
  logic               meas_done;

  logic us_tick;
  logic echo_s;
  logic echo_prev;
  logic echo_rise;
  logic echo_fall;

  // ------------------------------------------------------------------
  // Echo conditioning and edge detection
  // ------------------------------------------------------------------
`ifdef ULTRASONIC_ECHO_SYNC_EN
  logic echo_meta;
  logic echo_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  assign echo_s = echo_sync;
`else
  assign echo_s = echo;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      echo_prev <= 1'b0;
    end else begin
      echo_prev <= echo_s;
    end
  end

  assign echo_rise = echo_s & ~echo_prev;
  assign echo_fall = ~echo_s & echo_prev;

  assign us_tick = (presc == PRESC_LAST);

  // ------------------------------------------------------------------
  // Measurement FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_TRIG;
      trigger   <= 1'b0;
      distance  <= '0;
      presc     <= '0;
      trig_cnt  <= '0;
      sub_cnt   <= '0;
      cm_cnt    <= '0;
      to_cnt    <= '0;
      cyc_cnt   <= '0;
      meas_done <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      presc   <= us_tick ? '0 : presc + 1'b1;

      case (state)
        S_TRIG: begin
          if (!trigger) begin
            // Only reached straight after reset: this edge is the trigger
            // start, so it restarts the counters exactly as HOLD->TRIG does.
            trigger  <= 1'b1;
            presc    <= '0;
            trig_cnt <= '0;
            cyc_cnt  <= '0;
          end else if (us_tick) begin
            if (trig_cnt == TRIG_LAST) begin
              trigger <= 1'b0;
              state   <= S_WAIT_ECHO;
              presc   <= '0;
              to_cnt  <= '0;
            end else begin
              trig_cnt <= trig_cnt + 1'b1;
            end
          end
        end

        S_WAIT_ECHO: begin
          if (to_cnt == TO_LAST) begin
            distance <= NO_TARGET;
            state    <= S_HOLD;
            presc    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (echo_rise) begin
              state     <= S_MEASURE;
              presc     <= '0;
              sub_cnt   <= '0;
              cm_cnt    <= '0;
              meas_done <= 1'b0;
            end
          end
        end

        S_MEASURE: begin
          if (meas_done) begin
            // The falling-edge cycle was still counted; latch the total now.
            distance  <= cm_cnt;
            meas_done <= 1'b0;
            state     <= S_HOLD;
            presc     <= '0;
          end else if (to_cnt == TO_LAST) begin
            distance <= NO_TARGET;
            state    <= S_HOLD;
            presc    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (us_tick) begin
              if (sub_cnt == SUB_LAST) begin
                sub_cnt <= '0;
                if (cm_cnt != '1) begin
                  cm_cnt <= cm_cnt + 14'd1;
                end
              end else begin
                sub_cnt <= sub_cnt + 1'b1;
              end
            end
            if (echo_fall) begin
              meas_done <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (cyc_cnt == CYC_LAST) begin
            state    <= S_TRIG;
            trigger  <= 1'b1;
            presc    <= '0;
            trig_cnt <= '0;
            cm_cnt   <= '0;
            cyc_cnt  <= '0;
          end
        end

        default: begin
          state   <= S_TRIG;
          trigger <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger
//   Self-checking bench for ultrasonic_ranger using a scaled-down timebase
//   (1 tick per us, 10 us trigger, 58 us/cm, 3000 us timeout, 6000 us period).
//   Each measurement period is predicted from the echo pulse's start and
//   width, and trigger/distance are compared every cycle of that period.

module tb_ultrasonic_ranger;

  localparam int TPU  = 1;
  localparam int TRIG = 10;
  localparam int UPC  = 58;
  localparam int TO   = 3000;
  localparam int CYC  = 6000;

`ifdef ULTRASONIC_ECHO_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        echo = 1'b0;
  logic        trigger;
  logic [13:0] distance;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [13:0] model_dist = '0;

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .TICKS_PER_US(TPU),
    .TRIG_US     (TRIG),
    .US_PER_CM   (UPC),
    .TIMEOUT_US  (TO),
    .CYCLE_US    (CYC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .echo    (echo),
    .trigger (trigger),
    .distance(distance)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Echo is high on the clock edges a .. a+h-1 after the trigger start.
  // Returns the cycle after which distance takes its new value, and that value.
  function automatic void predict(input int a, input int h,
                                  output int ev, output logic [13:0] val);
    int rise_seen;
    int fall_seen;
    int cm;
    rise_seen = a + LAT - 1;
    fall_seen = rise_seen + h;
    ev  = TRIG + TO;
    val = 14'h3FFF;
    if (h > 0 && rise_seen > TRIG && rise_seen < TRIG + TO && fall_seen < TRIG + TO) begin
      ev = fall_seen + 1;
      cm = h / (TPU * UPC);
      if (cm > 16383) cm = 16383;
      val = 14'(cm);
    end
  endfunction

  // Starts right after the trigger-start edge and ends right after the next one.
  task automatic run_period(input string name, input int a, input int h);
    int          ev;
    logic [13:0] val;
    int          trig_bad = 0;
    int          dist_bad = 0;
    int          t_k = -1;
    int          d_k = -1;
    logic        t_got = 1'b0;
    logic        t_exp = 1'b0;
    logic [13:0] d_got = '0;
    logic [13:0] d_exp = '0;
    logic        exp_t;
    logic [13:0] exp_d;
    predict(a, h, ev, val);
    for (int k = 1; k < CYC; k++) begin
      echo = (k >= a && k < a + h);
      step;
      exp_t = (k < TRIG);
      exp_d = (k >= ev) ? val : model_dist;
      if (trigger !== exp_t) begin
        if (trig_bad == 0) begin
          t_k = k; t_got = trigger; t_exp = exp_t;
        end
        trig_bad++;
      end
      if (distance !== exp_d) begin
        if (dist_bad == 0) begin
          d_k = k; d_got = distance; d_exp = exp_d;
        end
        dist_bad++;
      end
    end
    echo = 1'b0;
    step;
    n_checks++;
    if (trig_bad != 0) begin
      n_fail++;
      $display("FAIL %s trigger_timing: %0d bad cycles, first at cycle %0d got %b expected %b",
               name, trig_bad, t_k, t_got, t_exp);
    end
    n_checks++;
    if (dist_bad != 0) begin
      n_fail++;
      $display("FAIL %s distance_timing: %0d bad cycles, first at cycle %0d got %h expected %h",
               name, dist_bad, d_k, d_got, d_exp);
    end
    n_checks++;
    if (distance !== val) begin
      n_fail++;
      $display("FAIL %s distance_final: got %h expected %h", name, distance, val);
    end
    n_checks++;
    if (trigger !== 1'b1) begin
      n_fail++;
      $display("FAIL %s next_trigger_start: got %b expected 1", name, trigger);
    end
    model_dist = val;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    echo  = 1'b0;
    step;
    step;
    n_checks++;
    if (trigger !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_trigger: got %b expected 0", trigger);
    end
    n_checks++;
    if (distance !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_distance: got %h expected 0000", distance);
    end
    reset = 1'b0;
    step;
    n_checks++;
    if (trigger !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_trigger: got %b expected 1", trigger);
    end
    n_checks++;
    if (distance !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_first_distance: got %h expected 0000", distance);
    end
    model_dist = '0;
  endtask

  task automatic test_echo_during_trigger;
    run_period("echo_in_trigger", 2, 5);
    run_period("echo_high_at_trigger_end", 5, 600);
  endtask

  task automatic test_distance;
    run_period("echo_580", 20, 580);
    run_period("echo_579", 15, 579);
  endtask

  task automatic test_stuck_high;
    run_period("echo_stuck_high", 50, 4000);
  endtask

  task automatic test_random;
    int a;
    int h;
    for (int i = 0; i < 2; i++) begin
      a = int'($urandom_range(11, 300));
      h = int'($urandom_range(58, 2600));
      run_period("random_echo", a, h);
    end
  endtask

  task automatic test_no_echo;
    run_period("no_echo", 0, 0);
  endtask

  task automatic test_reset_mid_measure;
    for (int k = 1; k <= 300; k++) begin
      echo = (k >= 20 && k < 1020);
      step;
    end
    n_checks++;
    if (distance !== model_dist) begin
      n_fail++;
      $display("FAIL mid_measure_hold: got %h expected %h", distance, model_dist);
    end
    reset = 1'b1;
    step;
    n_checks++;
    if (trigger !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_trigger: got %b expected 0", trigger);
    end
    n_checks++;
    if (distance !== 14'd0) begin
      n_fail++;
      $display("FAIL mid_reset_distance: got %h expected 0000", distance);
    end
    reset = 1'b0;
    echo  = 1'b0;
    step;
    n_checks++;
    if (trigger !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got %b expected 1", trigger);
    end
    model_dist = '0;
    run_period("after_reset", 30, 116);
  endtask

  initial begin
    test_reset;
    test_echo_during_trigger;
    test_distance;
    test_stuck_high;
    test_random;
    test_no_echo;
    test_reset_mid_measure;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
